// File: rtl/filter2d_pkg.sv
// Shared types, defaults and arithmetic helpers for the streaming 3x3 filter.
package filter2d_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StRun,
        StFlush,
        StDrain
    } state_e;

    localparam int NumTaps = 9;

    // Row-major 3x3 smoothing kernel, sums to 128.
    localparam int DefaultCoef [NumTaps] = '{8, 16, 8, 16, 32, 16, 8, 16, 8};

    function automatic int acc_width(input int dw, input int cw);
        return dw + cw + 4;
    endfunction

    // Round half up, arithmetic shift, then clamp to [0, 2^dw-1].
    function automatic logic [31:0] round_sat(input logic signed [63:0] acc,
                                              input int shift, input int dw);
        logic signed [63:0] rnd;
        logic signed [63:0] max_val;
        if (shift > 0) begin
            rnd = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            rnd = acc;
        end
        max_val = (64'sd1 <<< dw) - 64'sd1;
        if (rnd < 64'sd0) begin
            return '0;
        end else if (rnd > max_val) begin
            return max_val[31:0];
        end
        return rnd[31:0];
    endfunction

endpackage

// File: rtl/filter2d_stream_if.sv
// Pixel stream bundle: input side (valid/ready/data) and output side with frame markers.
interface filter2d_stream_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sof;
    logic          out_eol;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sof, out_eol
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sof, out_eol
    );
endinterface

// File: rtl/filter2d_linebuf.sv
// Two-row circular line buffer; presents column {row y-2, row y-1, current} at the pointer.
module filter2d_linebuf #(
    parameter int WIDTH = 256,
    parameter int DW    = 8
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               clear,
    input  logic               en,
    input  logic [DW-1:0]      din,
    output logic [2:0][DW-1:0] col
);
    localparam int PtrW = $clog2(WIDTH);

    logic [PtrW-1:0] ptr_q;
    logic [DW-1:0]   row_a [WIDTH];
    logic [DW-1:0]   row_b [WIDTH];

    // Reads are combinational so the column is valid in the same cycle as the write.
    always_comb begin
        col[0] = row_a[ptr_q];
        col[1] = row_b[ptr_q];
        col[2] = din;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ptr_q <= '0;
        end else if (clear) begin
            ptr_q <= '0;
        end else if (en) begin
            if (ptr_q == PtrW'(WIDTH - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            row_a[ptr_q] <= row_b[ptr_q];
            row_b[ptr_q] <= din;
        end
    end

endmodule

// File: rtl/filter2d_stream.sv
// Streaming 3x3 convolution over one raster frame, zero-padded borders, 3-stage datapath.
module filter2d_stream
    import filter2d_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int DW     = 8,
    parameter int CW     = 8,
    parameter int SHIFT  = 7
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              h_write,
    input  logic [3:0]        h_idx,
    input  logic [CW-1:0]     h_data,
    filter2d_stream_if.slave  px
);
    localparam int AW  = acc_width(DW, CW);
    localparam int PW  = DW + 1 + CW;
    localparam int XW  = $clog2(WIDTH);
    localparam int YW  = $clog2(HEIGHT + 2);
    localparam int OYW = $clog2(HEIGHT);

    state_e state_q, state_d;
    logic [XW-1:0]  kx_q, kx_d, ox_q, ox_d;
    logic [YW-1:0]  ky_q, ky_d;
    logic [OYW-1:0] oy_q, oy_d;
    logic           done_q, done_d;
    logic           lb_clear;

    logic signed [CW-1:0] coef_q [NumTaps];

    logic                 stall, accept, flush_slot, adv, out_slot, last_hs;
    logic [DW-1:0]        lb_din;
    logic [2:0][DW-1:0]   lb_col;

    logic                 v1_q, sof1_q, eol1_q, last1_q;
    logic [DW-1:0]        win_q [NumTaps];
    logic [NumTaps-1:0]   mask_q, mask_d;
    logic [2:0]           row_ok, col_ok;

    logic                 v2_q, sof2_q, eol2_q, last2_q;
    logic signed [DW:0]   tap [NumTaps];
    logic signed [PW-1:0] prod_d [NumTaps];
    logic signed [PW-1:0] prod_q [NumTaps];

    logic signed [AW-1:0] acc_sum;
    logic                 out_valid_q, out_sof_q, out_eol_q, out_last_q;
    logic [DW-1:0]        out_data_q;

    assign stall      = out_valid_q && !px.out_ready;
    assign px.in_ready = (state_q == StFill || state_q == StRun) && !stall;
    assign accept     = px.in_valid && px.in_ready;
    assign flush_slot = (state_q == StFlush) && !stall;
    assign adv        = accept || flush_slot;
    assign out_slot   = adv && (state_q == StRun || state_q == StFlush);
    assign last_hs    = out_valid_q && px.out_ready && out_last_q;
    assign lb_din     = accept ? px.in_data : '0;

    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign px.out_valid  = out_valid_q;
    assign px.out_data   = out_data_q;
    assign px.out_sof    = out_sof_q;
    assign px.out_eol    = out_eol_q;

    always_comb begin
        state_d  = state_q;
        kx_d     = kx_q;
        ky_d     = ky_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        done_d   = 1'b0;
        lb_clear = 1'b0;
        if (adv) begin
            if (kx_q == XW'(WIDTH - 1)) begin
                kx_d = '0;
                ky_d = ky_q + 1'b1;
            end else begin
                kx_d = kx_q + 1'b1;
            end
        end
        if (out_slot) begin
            if (ox_q == XW'(WIDTH - 1)) begin
                ox_d = '0;
                oy_d = oy_q + 1'b1;
            end else begin
                ox_d = ox_q + 1'b1;
            end
        end
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StFill;
                    kx_d     = '0;
                    ky_d     = '0;
                    ox_d     = '0;
                    oy_d     = '0;
                    lb_clear = 1'b1;
                end
            end
            // Input k = WIDTH sits at (x=0, y=1).
            StFill: if (accept && kx_q == '0 && ky_q == YW'(1)) state_d = StRun;
            StRun: begin
                if (accept && kx_q == XW'(WIDTH - 1) && ky_q == YW'(HEIGHT - 1)) begin
                    state_d = StFlush;
                end
            end
            // Last virtual slot k = WIDTH*HEIGHT+WIDTH sits at (x=0, y=HEIGHT+1).
            StFlush: if (flush_slot && kx_q == '0 && ky_q == YW'(HEIGHT + 1)) state_d = StDrain;
            StDrain: begin
                if (last_hs) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= StIdle;
            kx_q    <= '0;
            ky_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NumTaps; i++) coef_q[i] <= CW'(DefaultCoef[i]);
        end else if (h_write && state_q == StIdle && h_idx <= 4'd8) begin
            coef_q[h_idx] <= h_data;
        end
    end

    filter2d_linebuf #(
        .WIDTH (WIDTH),
        .DW    (DW)
    ) u_linebuf (
        .clk     (clk),
        .n_reset (n_reset),
        .clear   (lb_clear),
        .en      (adv),
        .din     (lb_din),
        .col     (lb_col)
    );

    // Out-of-frame taps are masked so stale line buffer contents never reach the sum.
    always_comb begin
        row_ok[0] = (oy_q != '0);
        row_ok[1] = 1'b1;
        row_ok[2] = (oy_q != OYW'(HEIGHT - 1));
        col_ok[0] = (ox_q != '0);
        col_ok[1] = 1'b1;
        col_ok[2] = (ox_q != XW'(WIDTH - 1));
        mask_d    = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) mask_d[r*3+c] = row_ok[r] & col_ok[c];
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            v1_q    <= 1'b0;
            sof1_q  <= 1'b0;
            eol1_q  <= 1'b0;
            last1_q <= 1'b0;
            mask_q  <= '0;
            for (int i = 0; i < NumTaps; i++) win_q[i] <= '0;
        end else if (!stall) begin
            v1_q <= out_slot;
            if (adv) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r*3]   <= win_q[r*3+1];
                    win_q[r*3+1] <= win_q[r*3+2];
                    win_q[r*3+2] <= lb_col[r];
                end
                mask_q  <= mask_d;
                sof1_q  <= (ox_q == '0) && (oy_q == '0);
                eol1_q  <= (ox_q == XW'(WIDTH - 1));
                last1_q <= (ox_q == XW'(WIDTH - 1)) && (oy_q == OYW'(HEIGHT - 1));
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NumTaps; i++) begin
            tap[i]    = mask_q[i] ? {1'b0, win_q[i]} : '0;
            prod_d[i] = PW'(tap[i]) * PW'(coef_q[i]);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            v2_q    <= 1'b0;
            sof2_q  <= 1'b0;
            eol2_q  <= 1'b0;
            last2_q <= 1'b0;
            for (int i = 0; i < NumTaps; i++) prod_q[i] <= '0;
        end else if (!stall) begin
            v2_q <= v1_q;
            if (v1_q) begin
                for (int i = 0; i < NumTaps; i++) prod_q[i] <= prod_d[i];
                sof2_q  <= sof1_q;
                eol2_q  <= eol1_q;
                last2_q <= last1_q;
            end
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < NumTaps; i++) acc_sum = acc_sum + AW'(prod_q[i]);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                out_data_q <= DW'(round_sat(64'(acc_sum), SHIFT, DW));
                out_sof_q  <= sof2_q;
                out_eol_q  <= eol2_q;
                out_last_q <= last2_q;
            end
        end
    end

endmodule

// File: tb/tb_filter2d_stream.sv
// Self-checking bench: spot-check table plus randomized frames against a direct convolution model.
module tb_filter2d_stream;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;
    localparam int SH   = 7;

    typedef struct {
        int    cset;
        int    fill;
        int    x;
        int    y;
        int    exp;
        string name;
    } vec_t;

    logic       clk;
    logic       n_reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       h_write;
    logic [3:0] h_idx;
    logic [7:0] h_data;

    filter2d_stream_if #(.DW(8)) px ();

    filter2d_stream #(
        .WIDTH  (W),
        .HEIGHT (H),
        .DW     (8),
        .CW     (8),
        .SHIFT  (SH)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .h_write (h_write),
        .h_idx   (h_idx),
        .h_data  (h_data),
        .px      (px)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         coef_m [9];
    logic [7:0] frame [NPIX];
    int         got_data [NPIX];
    int         got_sof [NPIX];
    int         got_eol [NPIX];
    int         n_out;
    int         wr_idx;
    int         wr_val;
    vec_t       vecs [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Direct zero-padded 3x3 sum with round and clamp.
    function automatic int ref_pix(input int x, input int y);
        int acc;
        int r;
        acc = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (y + dy >= 0 && y + dy < H && x + dx >= 0 && x + dx < W)
                    acc += int'(frame[(y + dy) * W + x + dx]) * coef_m[(dy + 1) * 3 + dx + 1];
            end
        end
        r = (acc + (1 << (SH - 1))) >>> SH;
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    function automatic int coef_set(input int cset, input int i);
        case (cset)
            1:       return (i == 4) ? -128 : 0;
            2:       return 127;
            3:       return (i == 4) ? 127 : 0;
            default: return (i == 4) ? 32 : ((i % 2 == 1) ? 16 : 8);
        endcase
    endfunction

    task automatic write_coef(input int idx, input int val);
        @(negedge clk);
        h_write = 1'b1;
        h_idx   = 4'(idx);
        h_data  = 8'(val);
        @(negedge clk);
        h_write = 1'b0;
    endtask

    task automatic push_coefs();
        for (int i = 0; i < 9; i++) write_coef(i, coef_m[i]);
    endtask

    // wr_mode: 0 none, 1 write attempt while busy, 2 write in the start cycle.
    task automatic run_frame(input bit gaps, input bit ostall, input int wr_mode);
        int         k, ndone, acc9_cyc, first_cyc, post, hold_err, cyc;
        bit         cur_v, prev_stall;
        logic [7:0] prev_data;
        logic       prev_sof, prev_eol;
        k = 0; n_out = 0; ndone = 0; acc9_cyc = -1; first_cyc = -1; post = -1;
        hold_err = 0; cur_v = 1'b0; prev_stall = 1'b0;
        prev_data = '0; prev_sof = 1'b0; prev_eol = 1'b0;
        @(negedge clk);
        start = 1'b1;
        if (wr_mode == 2) begin
            h_write = 1'b1;
            h_idx   = 4'(wr_idx);
            h_data  = 8'(wr_val);
            coef_m[wr_idx] = wr_val;
        end
        @(negedge clk);
        start   = 1'b0;
        h_write = 1'b0;
        for (cyc = 0; cyc < 3000 && post != 0; cyc++) begin
            if (!cur_v && k < NPIX) cur_v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            px.in_valid  = cur_v;
            px.in_data   = cur_v ? frame[k] : 8'h00;
            px.out_ready = ostall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wr_mode == 1 && cyc == 20) begin
                h_write = 1'b1;
                h_idx   = 4'd4;
                h_data  = 8'h55;
            end else begin
                h_write = 1'b0;
            end
            #1;
            if (prev_stall && (!px.out_valid || px.out_data !== prev_data ||
                               px.out_sof !== prev_sof || px.out_eol !== prev_eol)) hold_err++;
            if (px.out_valid && !px.out_ready && px.in_ready) hold_err++;
            prev_stall = px.out_valid && !px.out_ready;
            prev_data  = px.out_data;
            prev_sof   = px.out_sof;
            prev_eol   = px.out_eol;
            if (px.out_valid && first_cyc < 0) first_cyc = cyc;
            if (px.out_valid && px.out_ready) begin
                if (n_out < NPIX) begin
                    got_data[n_out] = int'(px.out_data);
                    got_sof[n_out]  = int'(px.out_sof);
                    got_eol[n_out]  = int'(px.out_eol);
                end
                n_out++;
            end
            if (cur_v && px.in_ready) begin
                if (k == W + 1) acc9_cyc = cyc;
                k++;
                cur_v = 1'b0;
            end
            if (done) begin
                ndone++;
                if (post < 0) post = 3;
            end
            if (post > 0) post--;
            @(negedge clk);
        end
        px.in_valid  = 1'b0;
        px.out_ready = 1'b1;
        h_write      = 1'b0;
        check("frame_completes", int'(post == 0), 1);
        check("output_count", n_out, NPIX);
        check("done_pulses", ndone, 1);
        check("stall_hold", hold_err, 0);
        check("busy_after_frame", int'(busy), 0);
        if (!gaps && !ostall) check("latency", first_cyc - acc9_cyc, 3);
        for (int i = 0; i < NPIX && i < n_out; i++) begin
            check($sformatf("pix%0d_data", i), got_data[i], ref_pix(i % W, i / W));
            check($sformatf("pix%0d_sof", i), got_sof[i], int'(i == 0));
            check($sformatf("pix%0d_eol", i), got_eol[i], int'(i % W == W - 1));
        end
    endtask

    initial begin
        int k, idle_valid;
        vecs[0] = '{0, 100, 0, 0, 56, "corner_tl"};
        vecs[1] = '{0, 100, 3, 0, 75, "top_edge"};
        vecs[2] = '{0, 100, 3, 3, 100, "interior"};
        vecs[3] = '{0, 100, 7, 7, 56, "corner_br"};
        vecs[4] = '{0, 100, 0, 4, 75, "left_edge"};
        vecs[5] = '{1, 255, 3, 3, 0, "neg_clamp"};
        vecs[6] = '{2, 255, 0, 0, 255, "pos_clamp"};
        vecs[7] = '{3, 200, 5, 2, 198, "center_only"};

        n_reset = 1'b0; start = 1'b0; h_write = 1'b0; h_idx = '0; h_data = '0;
        px.in_valid = 1'b0; px.in_data = '0; px.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) coef_m[i] = coef_set(0, i);
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_in_ready", int'(px.in_ready), 0);
        check("rst_out_valid", int'(px.out_valid), 0);
        check("rst_out_data", int'(px.out_data), 0);
        check("rst_out_sof", int'(px.out_sof), 0);
        check("rst_out_eol", int'(px.out_eol), 0);
        n_reset = 1'b1;

        // Input offered while idle must not be taken.
        px.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_in_ready", int'(px.in_ready), 0);
        check("idle_busy", int'(busy), 0);
        px.in_valid = 1'b0;

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 9; i++) coef_m[i] = coef_set(vecs[v].cset, i);
            push_coefs();
            for (int i = 0; i < NPIX; i++) frame[i] = 8'(vecs[v].fill);
            run_frame(1'b0, 1'b0, 0);
            check(vecs[v].name, got_data[vecs[v].y * W + vecs[v].x], vecs[v].exp);
        end

        // Center-only 127 on random data; latency checked inside.
        for (int i = 0; i < NPIX; i++) frame[i] = 8'($urandom_range(0, 255));
        run_frame(1'b0, 1'b0, 0);

        // Random kernel with input gaps and output backpressure, then without.
        for (int i = 0; i < 9; i++) coef_m[i] = int'($urandom_range(0, 60)) - 20;
        push_coefs();
        for (int i = 0; i < NPIX; i++) frame[i] = 8'($urandom_range(0, 255));
        run_frame(1'b1, 1'b1, 0);
        run_frame(1'b0, 1'b0, 0);

        // Out-of-range index in idle and writes while busy leave the kernel alone.
        write_coef(12, 99);
        run_frame(1'b1, 1'b1, 1);

        // Write issued together with start applies to that frame.
        wr_idx = 0;
        wr_val = -50;
        run_frame(1'b0, 1'b1, 2);

        // Reset mid-frame: no stale outputs, defaults restored.
        for (int i = 0; i < 9; i++) coef_m[i] = coef_set(3, i);
        push_coefs();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            px.in_valid = 1'b1;
            px.in_data  = frame[k];
            #1;
            if (px.in_ready) k++;
            @(negedge clk);
        end
        n_reset = 1'b0;
        px.in_valid = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_out_valid", int'(px.out_valid), 0);
        check("midrst_out_data", int'(px.out_data), 0);
        check("midrst_in_ready", int'(px.in_ready), 0);
        @(negedge clk);
        n_reset = 1'b1;
        idle_valid = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (px.out_valid) idle_valid++;
        end
        check("post_rst_quiet", idle_valid, 0);
        for (int i = 0; i < 9; i++) coef_m[i] = coef_set(0, i);
        for (int i = 0; i < NPIX; i++) frame[i] = 8'd100;
        run_frame(1'b0, 1'b0, 0);
        check("post_rst_first", got_data[0], 56);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter2d_stream.md
Name: filter2d_stream

Overview:
- Streaming 3x3 2D convolution over one raster-order frame; accepts and emits up to one pixel per clock.
- Two internal line buffers replace the 9-reads-per-pixel memory fetch, so the source never re-reads memory.
- Sits between a pixel source (DMA or sensor front end) and a pixel sink with valid/ready on both sides.
- Adds generic frame size, data and coefficient widths, programmable shift, output backpressure and end-of-frame flush.

Parameters:
- WIDTH, 256, pixels per line (>=3).
- HEIGHT, 256, lines per frame (>=3).
- DW, 8, pixel width, unsigned.
- CW, 8, coefficient width, signed two's complement.
- SHIFT, 7, right shift applied after accumulation; rounding adds 1<<(SHIFT-1) before the shift.

Ports:
- clk  in  1  clock.
- n_reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that starts a frame; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until the cycle after the last output handshake.
- done  out  1  one-cycle pulse in the cycle after the last output handshake.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept the input pixel.
- in_data  in  DW  input pixel.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  sink accepts the output pixel.
- out_data  out  DW  filtered, saturated output pixel.
- out_sof  out  1  qualifies output pixel (0,0).
- out_eol  out  1  qualifies an output pixel with x=WIDTH-1.
- h_write  in  1  coefficient write strobe.
- h_idx  in  4  coefficient index 0..8, row-major; top-left tap is 0.
- h_data  in  CW  coefficient value.

Behaviour:
- Reset values:
  - busy=0, done=0, in_ready=0, out_valid=0, out_data=0, out_sof=0, out_eol=0.
  - Counters, line buffer pointers and pipeline valid bits are cleared.
  - Coefficients load defaults {8,16,8,16,32,16,8,16,8}.
- Reset asserted mid-frame aborts the frame immediately. No partial outputs appear after reset is released.
- Coefficient writes:
  - Accepted only when busy=0. Ignored while busy=1.
  - A write with h_idx>8 is ignored.
  - h_write and start in the same cycle: the write takes effect and the frame uses the new value.
- FSM states: IDLE, FILL, RUN, FLUSH, DRAIN.
  - IDLE -> FILL on start.
  - FILL: accepts the first WIDTH+1 inputs. No outputs are produced.
  - FILL -> RUN after input index WIDTH is accepted.
  - RUN: every accepted input k (k>=WIDTH+1) generates output k-WIDTH-1, where output index = y*WIDTH+x.
  - RUN -> FLUSH after input index WIDTH*HEIGHT-1 is accepted.
  - FLUSH: generates the remaining WIDTH+1 outputs internally, one per cycle when not stalled. in_ready=0.
  - FLUSH -> DRAIN once all outputs have been issued into the pipeline.
  - DRAIN -> IDLE on the last output handshake. done pulses and busy falls in the following cycle.
- Borders: taps outside the frame contribute zero (zero padding). Out-of-frame taps are masked, never read from stale line buffer data.
- Arithmetic:
  - Each product is DW+1-bit signed pixel times CW-bit signed coefficient.
  - Sum of 9 products goes into an accumulator of DW+CW+4 bits, signed.
  - rnd = (acc + (1<<(SHIFT-1))) >>> SHIFT, arithmetic shift.
  - out = 0 if rnd<0; out = 2^DW-1 if rnd>2^DW-1; otherwise rnd.
- Pipeline:
  - Stage 1 registers the window and its mask.
  - Stage 2 registers the 9 products.
  - Stage 3 registers the sum, round and saturate into out_data.
  - Latency from the accepted input k (or its FLUSH slot) to out_valid for output k-WIDTH-1 is 3 cycles with no stall.
- Backpressure:
  - out_valid=1 and out_ready=0 freezes the entire pipeline, the FSM and the counters.
  - While frozen, in_ready=0 and out_data/out_sof/out_eol are held stable.
  - in_ready = busy and state in {FILL, RUN} and no stall.
- Input-side stall: in_valid=0 during RUN inserts a bubble. out_valid goes low 3 cycles later; no output is produced.
- The FSM does not leave IDLE without start, and in_valid while IDLE is not accepted.
- Line buffers: two rows of WIDTH x DW. Write pointer wraps at WIDTH-1 -> 0 each line.

Decomposition:
- Package filter2d_pkg holds:
  - the FSM state enum;
  - the default coefficient array;
  - the function computing accumulator width;
  - the round/saturate function.
- Sub-module filter2d_linebuf: two-row circular line buffer with a column pointer. It outputs the column {row y-2, row y-1, current} on each accepted input and is stalled by the same enable.

Test Plan:
- Default coefficients, WIDTH=HEIGHT=8, constant frame of 100 -> interior outputs 100 (100*128/128); corner (0,0) gives 72*100/128 rounded = 56; top edge gives 96*100/128 = 75; exactly 64 outputs; done pulses once; out_sof only on the first output, out_eol every 8th.
- Write h=0 except h[4]=127 and SHIFT=7, random frame -> out=(p*127+64)>>7 per pixel in raster order; latency 3 cycles after input k+WIDTH+1.
- Write h[4]=-128, frame of 255 -> all outputs 0 (negative clamp); h[4]=127 with all other taps 127 on 255 input -> all outputs 255 (positive clamp).
- Random out_ready toggling (~50%) and random in_valid gaps -> output sequence bit-identical to the no-stall run; out_data stable whenever out_valid=1 and out_ready=0.
- h_write while busy and h_idx=12 in IDLE -> coefficients unchanged; frame output matches the prior coefficients.
- Assert n_reset mid-RUN, release, start a new frame -> no stale outputs; first output is the new frame's (0,0) with out_sof=1; defaults restored.
